// File: rtl/blink_monitor_if.sv
// blink_monitor_if: LED-monitor bus between the observed board and the checker.
// master drives leds_in/clr_err and reads the status; slave is the monitor itself.
interface blink_monitor_if;
  logic [7:0]  leds_in;
  logic        clr_err;
  logic        locked;
  logic        period_done;
  logic [15:0] period_count;
  logic [31:0] last_on_len;
  logic [31:0] last_off_len;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output leds_in, clr_err,
    input  locked, period_done, period_count,
    input  last_on_len, last_off_len, err, err_code
  );

  modport slave (
    input  leds_in, clr_err,
    output locked, period_done, period_count,
    output last_on_len, last_off_len, err, err_code
  );
endinterface

// File: rtl/blink_monitor.sv
// blink_monitor: measures LED ON/OFF hold times and checks them against windows.
// Ports: clk, rst (async high), bus (slave: leds_in, clr_err in; status out).
// Optional BLINK_MON_GLITCH_FILTER_EN: debounce the synchronized LED value.
module blink_monitor #(
  parameter logic [7:0]  ON_PATTERN    = 8'h55,
  parameter logic [7:0]  OFF_PATTERN   = 8'h00,
  parameter int unsigned ON_CYCLES     = 100_000_000,
  parameter int unsigned OFF_CYCLES    = 50_000_000,
  parameter int unsigned TOL           = 16,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  blink_monitor_if.slave   bus
);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_MON  = 2'd1;
  localparam logic [1:0] S_MOFF = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ILL   = 2'b01;
  localparam logic [1:0] E_SHORT = 2'b10;
  localparam logic [1:0] E_LONG  = 2'b11;

  localparam logic [31:0] ON_MIN  = 32'(ON_CYCLES - TOL);
  localparam logic [31:0] ON_MAX  = 32'(ON_CYCLES + TOL);
  localparam logic [31:0] OFF_MIN = 32'(OFF_CYCLES - TOL);
  localparam logic [31:0] OFF_MAX = 32'(OFF_CYCLES + TOL);

  logic [7:0]  sync1_q, sync2_q;
  logic [7:0]  s, s_prev_q;
  logic        edge_s;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  st_q, st_d;
  logic        locked_q, locked_d;
  logic        pd_q, pd_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] lon_q, lon_d;
  logic [31:0] loff_q, loff_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.leds_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef BLINK_MON_GLITCH_FILTER_EN
  localparam logic [7:0] FC = 8'(FILTER_CYCLES);

  logic [7:0] prev2_q, filt_q;
  logic [7:0] stab_q, stab_d;

  // stab counts how many cycles sync2 has held its current value
  always_comb begin
    if (sync2_q != prev2_q) stab_d = 8'd1;
    else if (stab_q >= FC)  stab_d = stab_q;
    else                    stab_d = stab_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev2_q <= '0;
      stab_q  <= '0;
      filt_q  <= '0;
    end else begin
      prev2_q <= sync2_q;
      stab_q  <= stab_d;
      if (stab_d >= FC) filt_q <= sync2_q;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign edge_s = (s != s_prev_q);

  // run length: 1 on the first cycle of a new value, saturating
  always_comb begin
    if (edge_s)            cnt_d = 32'd1;
    else if (cnt_q == '1)  cnt_d = cnt_q;
    else                   cnt_d = cnt_q + 32'd1;
  end

  always_comb begin
    st_d     = st_q;
    locked_d = locked_q;
    pd_d     = 1'b0;
    pcnt_d   = pcnt_q;
    lon_d    = lon_q;
    loff_d   = loff_q;
    err_d    = err_q;
    code_d   = code_q;
    unique case (st_q)
      S_HUNT: begin
        if (edge_s && s == ON_PATTERN)  st_d = S_MON;
        if (edge_s && s == OFF_PATTERN) st_d = S_MOFF;
      end
      S_MON: begin
        if (edge_s) begin
          st_d = S_ERR;
          if (s != OFF_PATTERN)  code_d = E_ILL;
          else if (cnt_q < ON_MIN) code_d = E_SHORT;
          else if (cnt_q > ON_MAX) code_d = E_LONG;
          else begin
            st_d  = S_MOFF;
            lon_d = cnt_q;
          end
        end else if (cnt_q >= ON_MAX) begin
          // counter is about to pass the window: fail now
          st_d   = S_ERR;
          code_d = E_LONG;
        end
      end
      S_MOFF: begin
        if (edge_s) begin
          st_d = S_ERR;
          if (s != ON_PATTERN)      code_d = E_ILL;
          else if (cnt_q < OFF_MIN) code_d = E_SHORT;
          else if (cnt_q > OFF_MAX) code_d = E_LONG;
          else begin
            st_d     = S_MON;
            loff_d   = cnt_q;
            pd_d     = 1'b1;
            locked_d = 1'b1;
            if (pcnt_q != '1) pcnt_d = pcnt_q + 16'd1;
          end
        end else if (cnt_q >= OFF_MAX) begin
          st_d   = S_ERR;
          code_d = E_LONG;
        end
      end
      S_ERR: begin
        if (bus.clr_err) begin
          st_d   = S_HUNT;
          err_d  = 1'b0;
          code_d = E_NONE;
        end
      end
      default: st_d = S_HUNT;
    endcase
    if (st_q != S_ERR && st_d == S_ERR) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q <= '0;
      cnt_q    <= '0;
      st_q     <= S_HUNT;
      locked_q <= 1'b0;
      pd_q     <= 1'b0;
      pcnt_q   <= '0;
      lon_q    <= '0;
      loff_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
    end else begin
      s_prev_q <= s;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      locked_q <= locked_d;
      pd_q     <= pd_d;
      pcnt_q   <= pcnt_d;
      lon_q    <= lon_d;
      loff_q   <= loff_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.period_done  = pd_q;
  assign bus.period_count = pcnt_q;
  assign bus.last_on_len  = lon_q;
  assign bus.last_off_len = loff_q;
  assign bus.err          = err_q;
  assign bus.err_code     = code_q;

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: run-level reference model with an event scoreboard.
// Stimulus is a list of (value, hold) runs; expected events are queued.
module tb_blink_monitor;

  localparam int ON_C  = 8;
  localparam int OFF_C = 4;
  localparam int TOL   = 1;
  localparam logic [7:0] ONP  = 8'h55;
  localparam logic [7:0] OFFP = 8'h00;
  localparam int ON_MIN  = ON_C - TOL;
  localparam int ON_MAX  = ON_C + TOL;
  localparam int OFF_MIN = OFF_C - TOL;
  localparam int OFF_MAX = OFF_C + TOL;
  localparam int HOLD    = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blink_monitor_if bus ();

  blink_monitor #(
    .ON_PATTERN(ONP), .OFF_PATTERN(OFFP),
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C),
    .TOL(TOL), .FILTER_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         cyc;
    int         cnt;
    int         on;
    int         off;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [7:0] v;
    int         len;
  } run_t;
  run_t seg[$];

  // run-level model state
  int         m_st;
  int         m_len;
  int         m_cnt, m_on, m_off;
  bit         m_lock, m_err;
  logic [1:0] m_code;
  logic [7:0] cur_v;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  ev_t  mev;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      err_prev <= 1'b0;
    end else begin
      if (bus.period_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_period_done at cyc %0d", cyc);
        end else begin
          mev = exp_q.pop_front();
          chk("pd_kind", 64'(mev.is_err), 64'(0));
          chk("pd_cycle", 64'(cyc), 64'(mev.cyc));
          chk("pd_count", 64'(bus.period_count), 64'(mev.cnt));
          chk("pd_on_len", 64'(bus.last_on_len), 64'(mev.on));
          chk("pd_off_len", 64'(bus.last_off_len), 64'(mev.off));
          chk("pd_locked", 64'(bus.locked), 64'(1));
        end
      end
      if (bus.err && !err_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err code %0d at cyc %0d",
                   bus.err_code, cyc);
        end else begin
          mev = exp_q.pop_front();
          chk("err_kind", 64'(mev.is_err), 64'(1));
          chk("err_cycle", 64'(cyc), 64'(mev.cyc));
          chk("err_code", 64'(bus.err_code), 64'(mev.code));
          chk("err_locked", 64'(bus.locked), 64'(0));
        end
      end
      err_prev <= bus.err;
    end
  end

  task automatic push_err(logic [1:0] code, int c);
    ev_t e;
    m_st   = 3;
    m_err  = 1'b1;
    m_code = code;
    m_lock = 1'b0;
    e = '{1'b1, code, c, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  // new run of value v, hold L, first captured on posedge P
  task automatic model_run(logic [7:0] v, int L, int P);
    ev_t e;
    case (m_st)
      0: begin
        if (v == ONP) m_st = 1;
        else if (v == OFFP) m_st = 2;
      end
      1: begin
        if (v == OFFP && m_len >= ON_MIN) begin
          m_on = m_len;
          m_st = 2;
        end else begin
          push_err((v == OFFP) ? 2'b10 : 2'b01, P + 2);
        end
      end
      2: begin
        if (v == ONP && m_len >= OFF_MIN) begin
          m_off = m_len;
          if (m_cnt < 65535) m_cnt++;
          m_lock = 1'b1;
          m_st = 1;
          e = '{1'b0, 2'b00, P + 2, m_cnt, m_on, m_off};
          exp_q.push_back(e);
        end else begin
          push_err((v == ONP) ? 2'b10 : 2'b01, P + 2);
        end
      end
      default: ;
    endcase
    if (m_st == 1 && L > ON_MAX) push_err(2'b11, P + 2 + ON_MAX);
    else if (m_st == 2 && L > OFF_MAX) push_err(2'b11, P + 2 + OFF_MAX);
    m_len = L;
  endtask

  task automatic drive_seg();
    int L;
    for (int i = 0; i < seg.size(); i++) begin
      L = (i == seg.size() - 1) ? HOLD : seg[i].len;
      @(negedge clk);
      bus.leds_in = seg[i].v;
      model_run(seg[i].v, L, cyc + 1);
      cur_v = seg[i].v;
      repeat (L - 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d events never seen", tag, exp_q.size());
      exp_q.delete();
    end
    chk({tag, "_locked"}, 64'(bus.locked), 64'(m_lock));
    chk({tag, "_count"}, 64'(bus.period_count), 64'(m_cnt));
    chk({tag, "_on_len"}, 64'(bus.last_on_len), 64'(m_on));
    chk({tag, "_off_len"}, 64'(bus.last_off_len), 64'(m_off));
    chk({tag, "_err"}, 64'(bus.err), 64'(m_err));
    chk({tag, "_code"}, 64'(bus.err_code), 64'(m_code));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_locked"}, 64'(bus.locked), 64'(0));
    chk({tag, "_pd"}, 64'(bus.period_done), 64'(0));
    chk({tag, "_count"}, 64'(bus.period_count), 64'(0));
    chk({tag, "_on_len"}, 64'(bus.last_on_len), 64'(0));
    chk({tag, "_off_len"}, 64'(bus.last_off_len), 64'(0));
    chk({tag, "_err"}, 64'(bus.err), 64'(0));
    chk({tag, "_code"}, 64'(bus.err_code), 64'(0));
  endtask

  // end of segment: compare final state, then exercise clr_err
  task automatic finish_seg(string tag);
    check_state(tag);
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    if (m_err) begin
      m_st = 0; m_err = 1'b0; m_code = 2'b00;
    end
    chk({tag, "_clr_err"}, 64'(bus.err), 64'(0));
    chk({tag, "_clr_code"}, 64'(bus.err_code), 64'(0));
    chk({tag, "_clr_locked"}, 64'(bus.locked), 64'(m_lock));
    chk({tag, "_clr_count"}, 64'(bus.period_count), 64'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.leds_in = 8'h00;
    bus.clr_err = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_len = 0; m_cnt = 0; m_on = 0; m_off = 0;
    m_lock = 1'b0; m_err = 1'b0; m_code = 2'b00;
    cur_v = 8'h00;
    check_zero("reset");
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
  endtask

  task automatic add(logic [7:0] v, int len);
    run_t r;
    r.v = v;
    r.len = len;
    seg.push_back(r);
  endtask

  task automatic gen_seg();
    logic [7:0] prev, v;
    int n, r, len;
    seg.delete();
    prev = cur_v;
    n = $urandom_range(6, 14);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        do v = 8'($urandom);
        while (v == ONP || v == OFFP || v == prev);
      end else if (prev == ONP) v = OFFP;
      else if (prev == OFFP) v = ONP;
      else v = r[0] ? ONP : OFFP;
      if (v == ONP)
        len = ($urandom_range(0, 99) < 85) ?
              $urandom_range(ON_MIN, ON_MAX) : $urandom_range(1, ON_MAX + 3);
      else if (v == OFFP)
        len = ($urandom_range(0, 99) < 85) ?
              $urandom_range(OFF_MIN, OFF_MAX) : $urandom_range(1, OFF_MAX + 3);
      else
        len = $urandom_range(1, 4);
      add(v, len);
      prev = v;
    end
  endtask

  initial begin
    bus.leds_in = 8'h00;
    bus.clr_err = 1'b0;

    // idle after reset, then three clean periods and a stuck ON
    do_reset();
    repeat (20) @(negedge clk);
    seg.delete();
    for (int k = 0; k < 3; k++) begin
      add(ONP, 8); add(OFFP, 4);
    end
    add(ONP, 0);
    drive_seg();
    finish_seg("lock_then_stuck");
    // lock again, then an ON phase that is too short
    seg.delete();
    add(OFFP, 3); add(ONP, 8); add(OFFP, 4);
    add(ONP, 8); add(OFFP, 4); add(ONP, 6); add(OFFP, 0);
    drive_seg();
    finish_seg("short_on");
    async_reset();

    // illegal pattern inside ON, recover with clr_err and re-lock
    do_reset();
    seg.delete();
    add(ONP, 8); add(OFFP, 4); add(ONP, 8); add(8'h0F, 0);
    drive_seg();
    finish_seg("illegal");
    seg.delete();
    add(ONP, 8); add(OFFP, 4); add(ONP, 9); add(OFFP, 5);
    add(ONP, 7); add(OFFP, 3); add(ONP, 0);
    drive_seg();
    finish_seg("relock");
    async_reset();

    for (int sc = 0; sc < 25; sc++) begin
      do_reset();
      gen_seg();
      drive_seg();
      finish_seg("rand_a");
      gen_seg();
      drive_seg();
      finish_seg("rand_b");
      async_reset();
    end

    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
